// File: rtl/cla_sub_pkg.sv
// Shared constants and stage-1 payload for the pipelined CLA subtractor.
// Build option: CLA_SUB_CLAMP_EN selects unsigned saturation of D.
package cla_sub_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LO_W_DEF  = 16;
  localparam int HI_W_DEF  = WIDTH_DEF - LO_W_DEF;

  typedef struct packed {
    logic [LO_W_DEF-1:0] lo_sum;
    logic                c_mid;
    logic [HI_W_DEF-1:0] a_hi;
    logic [HI_W_DEF-1:0] nb_hi;
  } s1_t;

endpackage

// File: rtl/cla_block.sv
// N-bit combinational carry-lookahead slice: 4-bit groups with
// group generate/propagate feeding the inter-group carry chain.
module cla_block #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  localparam int NG = (N + 3) / 4;
  localparam int NP = NG * 4;

  logic [NP-1:0] g;
  logic [NP-1:0] p;
  logic [NP-1:0] c;
  logic [NG:0]   cg;
  logic          gg;
  logic          gp;

  // Pad bits propagate so cg[NG] is the true carry out of bit N-1.
  always_comb begin
    g = '0;
    p = '1;
    g[N-1:0] = a & b;
    p[N-1:0] = a ^ b;
    c = '0;
    cg = '0;
    cg[0] = ci;
    gg = 1'b0;
    gp = 1'b1;
    for (int k = 0; k < NG; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      c[4*k] = cg[k];
      for (int j = 0; j < 4; j++) begin
        gg = g[4*k+j] | (p[4*k+j] & gg);
        gp = gp & p[4*k+j];
        if (j < 3)
          c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
      cg[k+1] = gg | (gp & cg[k]);
    end
  end

  assign s  = p[N-1:0] ^ c[N-1:0];
  assign co = cg[NG];

endmodule

// File: rtl/pipelined_cla_subtractor.sv
// Two-stage valid/ready subtractor D = A - B - BORROW_in on CLA slices.
// Build option: CLA_SUB_CLAMP_EN clamps D to 0 on final borrow.
module pipelined_cla_subtractor
  import cla_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LO_W  = LO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BORROW_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BORROW_out,
  output logic             OVF
);

  localparam int HI_W = WIDTH - LO_W;

  logic            s1_valid;
  s1_t             s1_q;
  logic            s1_load;
  logic            s2_load;
  logic [LO_W-1:0] lo_sum;
  logic            lo_co;
  logic [HI_W-1:0] hi_sum;
  logic            hi_co;
  logic [WIDTH-1:0] d_full;
  logic            ovf_next;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;

  // Subtraction as A + ~B + ~BORROW_in.
  cla_block #(.N(LO_W)) u_lo (
    .a  (A[LO_W-1:0]),
    .b  (~B[LO_W-1:0]),
    .ci (~BORROW_in),
    .s  (lo_sum),
    .co (lo_co)
  );

  cla_block #(.N(HI_W)) u_hi (
    .a  (s1_q.a_hi),
    .b  (s1_q.nb_hi),
    .ci (s1_q.c_mid),
    .s  (hi_sum),
    .co (hi_co)
  );

  assign d_full   = {hi_sum, s1_q.lo_sum};
  assign ovf_next = (s1_q.a_hi[HI_W-1] == s1_q.nb_hi[HI_W-1]) &&
                    (hi_sum[HI_W-1] != s1_q.a_hi[HI_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid    <= 1'b1;
        s1_q.lo_sum <= lo_sum;
        s1_q.c_mid  <= lo_co;
        s1_q.a_hi   <= A[WIDTH-1:LO_W];
        s1_q.nb_hi  <= ~B[WIDTH-1:LO_W];
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      D          <= '0;
      BORROW_out <= 1'b0;
      OVF        <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid  <= 1'b1;
        BORROW_out <= ~hi_co;
        OVF        <= ovf_next;
`ifdef CLA_SUB_CLAMP_EN
        D          <= hi_co ? d_full : '0;
`else
        D          <= d_full;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Scoreboard bench for pipelined_cla_subtractor: directed vectors,
// streaming, backpressure and mid-flight reset.
module tb_pipelined_cla_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        BORROW_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] D;
  logic        BORROW_out;
  logic        OVF;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ovf;
  } exp_t;

  exp_t        sbq[$];
  int          nvec = 0;
  int          nerr = 0;
  int          acc_cnt = 0;
  int          low_cnt = 0;
  bit          strict = 0;

  always #5 clk = ~clk;

  pipelined_cla_subtractor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .BORROW_in  (BORROW_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .D          (D),
    .BORROW_out (BORROW_out),
    .OVF        (OVF)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] clampd(input logic [31:0] d,
                                         input logic bo);
`ifdef CLA_SUB_CLAMP_EN
    return bo ? 32'h0 : d;
`else
    return d;
`endif
  endfunction

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic bi);
    logic [32:0] r;
    exp_t e;
    r = {1'b0, a} - {1'b0, b} - {32'h0, bi};
    e.bo  = r[32];
    e.ovf = (a[31] != b[31]) && (r[31] != a[31]);
    e.d   = clampd(r[31:0], r[32]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_beat", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("D", D, e.d);
        check("BORROW_out", {31'h0, BORROW_out}, {31'h0, e.bo});
        check("OVF", {31'h0, OVF}, {31'h0, e.ovf});
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic bi, input exp_t e);
    bit ok;
    int n;
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    BORROW_in = bi;
    ok = 0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      if (strict && !ok) low_cnt++;
      if (ok) sbq.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 32'h1, 32'h0);
    else acc_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic send_hand(input logic [31:0] a, input logic [31:0] b,
                           input logic bi, input logic [31:0] d,
                           input logic bo, input logic ovf);
    exp_t e;
    e.d   = clampd(d, bo);
    e.bo  = bo;
    e.ovf = ovf;
    send(a, b, bi, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", sbq.size(), 0);
  endtask

  task automatic latency_check(input logic [31:0] a,
                               input logic [31:0] b);
    send(a, b, 1'b0, model(a, b, 1'b0));
    @(negedge clk);
    check("lat_cycle1", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("lat_cycle2", {31'h0, out_valid}, 32'h1);
    drain();
  endtask

  logic [31:0] held;

  initial begin
    #12;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_D", D, 32'h0);
    check("rst_bo", {31'h0, BORROW_out}, 32'h0);
    check("rst_ovf", {31'h0, OVF}, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);

    latency_check(32'd100, 32'd58);

    send_hand(32'd100, 32'd58, 1'b0, 32'd42, 1'b0, 1'b0);
    send_hand(32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    send_hand(32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    send_hand(32'h00010000, 32'h1, 1'b1, 32'h0000FFFE, 1'b0, 1'b0);
    send_hand(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);
    send_hand(32'd5, 32'd5, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    send_hand(32'hFFFFFFFF, 32'h0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    send_hand(32'h12345678, 32'h00005679, 1'b0, 32'h1233FFFF, 1'b0, 1'b0);
    send_hand(32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    send_hand(32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h00000001, 1'b0, 1'b1);
    drain();

    strict = 1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rbi;
      ra  = $urandom;
      rb  = $urandom;
      rbi = 1'($urandom_range(0, 1));
      send(ra, rb, rbi, model(ra, rb, rbi));
    end
    strict = 0;
    drain();
    check("stream_in_ready_low", low_cnt, 0);

    out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        send_hand(32'd10, 32'd3, 1'b0, 32'd7, 1'b0, 1'b0);
        send_hand(32'd20, 32'd30, 1'b0, 32'hFFFFFFF6, 1'b1, 1'b0);
        send_hand(32'h00020000, 32'h00010001, 1'b0, 32'h0000FFFF,
                  1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        held = D;
        check("bp_out_valid", {31'h0, out_valid}, 32'h1);
        repeat (2) @(negedge clk);
        check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        check("bp_accepted", acc_cnt, 2);
        check("bp_D_held", D, held);
        check("bp_D_value", D, 32'd7);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send(32'd1, 32'd1, 1'b0, model(32'd1, 32'd1, 1'b0));
    send(32'd9, 32'd2, 1'b0, model(32'd9, 32'd2, 1'b0));
    @(negedge clk);
    check("mid_full", {31'h0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_D", D, 32'h0);
    sbq.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    latency_check(32'h00000003, 32'h00000005);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
